// File: rtl/hazard_tnew_tracker_pkg.sv
// Shared widths, bubble encoding and Tnew codes for the hazard tracker and
// the decoder that feeds it.
package hazard_tnew_tracker_pkg;

  localparam int ADDR_W = 5;
  localparam int TNEW_W = 3;
  localparam int CNT_W  = 32;

  localparam int BUBBLE_ADDR = 0;
  localparam int BUBBLE_TNEW = 0;

  typedef enum logic [2:0] {
    TNEW_ZERO = 3'd0,
    TNEW_ALU  = 3'd1,
    TNEW_LOAD = 3'd2
  } tnew_code_e;

  // STG_HOLD freezes the address but keeps counting Tnew down.
  typedef enum logic [1:0] {
    STG_LOAD   = 2'd0,
    STG_BUBBLE = 2'd1,
    STG_HOLD   = 2'd2
  } stage_op_e;

endpackage

// File: rtl/hazard_stage_reg.sv
// One pipeline {RegAddr, Tnew} entry with load, bubble and hold/decrement.
module hazard_stage_reg
  import hazard_tnew_tracker_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int TW = TNEW_W
) (
  input  logic          clk,
  input  logic          reset_n,
  input  stage_op_e     op,
  input  logic [AW-1:0] load_addr,
  input  logic [TW-1:0] load_tnew,
  output logic [AW-1:0] reg_addr,
  output logic [TW-1:0] tnew
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_addr <= '0;
      tnew     <= '0;
    end else begin
      case (op)
        STG_LOAD: begin
          reg_addr <= load_addr;
          // $0 never produces a hazard, so it always carries Tnew 0.
          tnew     <= (load_addr == '0) ? TW'(BUBBLE_TNEW) : load_tnew;
        end
        STG_BUBBLE: begin
          reg_addr <= AW'(BUBBLE_ADDR);
          tnew     <= TW'(BUBBLE_TNEW);
        end
        STG_HOLD: begin
          tnew <= (tnew == '0) ? '0 : tnew - TW'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_tnew_tracker.sv
// Producer side of hazard detection: carries RegAddr/Tnew through E, M, W,
// inserts bubbles on stall / MDU hold and counts stalled cycles.
module hazard_tnew_tracker #(
  parameter int ADDR_W = hazard_tnew_tracker_pkg::ADDR_W,
  parameter int TNEW_W = hazard_tnew_tracker_pkg::TNEW_W,
  parameter int CNT_W  = hazard_tnew_tracker_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] D_RegAddr,
  input  logic [TNEW_W-1:0] D_Tnew,
  input  logic              stall,
  input  logic              E_hold,
  output logic [ADDR_W-1:0] E_RegAddr,
  output logic [TNEW_W-1:0] E_Tnew,
  output logic [ADDR_W-1:0] M_RegAddr,
  output logic [TNEW_W-1:0] M_Tnew,
  output logic [ADDR_W-1:0] W_RegAddr,
  output logic              E_fwd_ok,
  output logic              M_fwd_ok,
  output logic [CNT_W-1:0]  stall_cnt
);
  import hazard_tnew_tracker_pkg::*;

  stage_op_e         e_op;
  stage_op_e         m_op;
  logic [TNEW_W-1:0] e_tnew_dec;

  // E_hold outranks stall: the held op stays in E and M gets the bubble.
  always_comb begin
    e_op = STG_LOAD;
    m_op = STG_LOAD;
    if (E_hold) begin
      e_op = STG_HOLD;
      m_op = STG_BUBBLE;
    end else if (stall) begin
      e_op = STG_BUBBLE;
    end
  end

  assign e_tnew_dec = (E_Tnew == '0) ? '0 : E_Tnew - TNEW_W'(1);

  hazard_stage_reg #(.AW(ADDR_W), .TW(TNEW_W)) u_e_stage (
    .clk       (clk),
    .reset_n   (reset_n),
    .op        (e_op),
    .load_addr (D_RegAddr),
    .load_tnew (D_Tnew),
    .reg_addr  (E_RegAddr),
    .tnew      (E_Tnew)
  );

  hazard_stage_reg #(.AW(ADDR_W), .TW(TNEW_W)) u_m_stage (
    .clk       (clk),
    .reset_n   (reset_n),
    .op        (m_op),
    .load_addr (E_RegAddr),
    .load_tnew (e_tnew_dec),
    .reg_addr  (M_RegAddr),
    .tnew      (M_Tnew)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      W_RegAddr <= '0;
      stall_cnt <= '0;
    end else begin
      W_RegAddr <= M_RegAddr;
      if (stall || E_hold) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  assign E_fwd_ok = (E_Tnew == '0) && (E_RegAddr != '0);
  assign M_fwd_ok = (M_Tnew == '0) && (M_RegAddr != '0);

endmodule

// File: tb/tb_hazard_tnew_tracker.sv
// Bench for hazard_tnew_tracker: directed vector table, random run against a
// ready-time reference model, counter wrap and asynchronous reset sequences.
module tb_hazard_tnew_tracker;

  localparam int AW = 5;
  localparam int TW = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] D_RegAddr = '0;
  logic [TW-1:0] D_Tnew = '0;
  logic          stall = 1'b0;
  logic          E_hold = 1'b0;
  logic [AW-1:0] E_RegAddr, M_RegAddr, W_RegAddr;
  logic [TW-1:0] E_Tnew, M_Tnew;
  logic          E_fwd_ok, M_fwd_ok;
  logic [CW-1:0] stall_cnt;

  hazard_tnew_tracker #(.ADDR_W(AW), .TNEW_W(TW), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .D_RegAddr (D_RegAddr),
    .D_Tnew    (D_Tnew),
    .stall     (stall),
    .E_hold    (E_hold),
    .E_RegAddr (E_RegAddr),
    .E_Tnew    (E_Tnew),
    .M_RegAddr (M_RegAddr),
    .M_Tnew    (M_Tnew),
    .W_RegAddr (W_RegAddr),
    .E_fwd_ok  (E_fwd_ok),
    .M_fwd_ok  (M_fwd_ok),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each stage remembers the cycle at which its result
  // becomes ready; Tnew is simply the remaining distance to that cycle.
  int            now;
  logic [AW-1:0] me_addr, mm_addr, mw_addr;
  int            me_ready, mm_ready;
  int            mcnt;

  function automatic int tnew_of(input logic [AW-1:0] a, input int ready);
    if (a == '0) return 0;
    return (ready > now) ? ready - now : 0;
  endfunction

  task automatic model_reset();
    now = 0; me_addr = '0; mm_addr = '0; mw_addr = '0;
    me_ready = 0; mm_ready = 0; mcnt = 0;
  endtask

  task automatic model_edge(input logic [AW-1:0] a, input logic [TW-1:0] t,
                            input logic s, input logic h);
    now++;
    mw_addr = mm_addr;
    if (h) begin
      mm_addr = '0; mm_ready = 0;
    end else begin
      mm_addr = me_addr; mm_ready = me_ready;
      if (s) begin
        me_addr = '0; me_ready = 0;
      end else begin
        me_addr = a; me_ready = now + int'(t);
      end
    end
    if (s || h) mcnt = (mcnt + 1) % (1 << CW);
  endtask

  task automatic check_model(input string tag);
    int et, mt;
    et = tnew_of(me_addr, me_ready);
    mt = tnew_of(mm_addr, mm_ready);
    chk({tag, ".E_RegAddr"}, E_RegAddr, me_addr);
    chk({tag, ".E_Tnew"}, E_Tnew, et);
    chk({tag, ".M_RegAddr"}, M_RegAddr, mm_addr);
    chk({tag, ".M_Tnew"}, M_Tnew, mt);
    chk({tag, ".W_RegAddr"}, W_RegAddr, mw_addr);
    chk({tag, ".E_fwd_ok"}, E_fwd_ok, (me_addr != '0) && (et == 0));
    chk({tag, ".M_fwd_ok"}, M_fwd_ok, (mm_addr != '0) && (mt == 0));
    chk({tag, ".stall_cnt"}, stall_cnt, mcnt);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".E_RegAddr"}, E_RegAddr, 0);
    chk({tag, ".E_Tnew"}, E_Tnew, 0);
    chk({tag, ".M_RegAddr"}, M_RegAddr, 0);
    chk({tag, ".M_Tnew"}, M_Tnew, 0);
    chk({tag, ".W_RegAddr"}, W_RegAddr, 0);
    chk({tag, ".E_fwd_ok"}, E_fwd_ok, 0);
    chk({tag, ".M_fwd_ok"}, M_fwd_ok, 0);
    chk({tag, ".stall_cnt"}, stall_cnt, 0);
  endtask

  task automatic step(input logic [AW-1:0] a, input logic [TW-1:0] t,
                      input logic s, input logic h);
    D_RegAddr = a; D_Tnew = t; stall = s; E_hold = h;
    @(posedge clk);
    model_edge(a, t, s, h);
    #1;
  endtask

  typedef struct {
    logic [AW-1:0] d_addr;
    logic [TW-1:0] d_tnew;
    logic          s;
    logic          h;
    logic [AW-1:0] e_addr;
    logic [TW-1:0] e_tnew;
    logic [AW-1:0] m_addr;
    logic [TW-1:0] m_tnew;
    logic [AW-1:0] w_addr;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t vecs[12];

  initial begin
    // load-use, stall bubble, MDU hold with stall, $0 normalisation
    vecs[0]  = '{5'd8, 3'd2, 1'b0, 1'b0, 5'd8, 3'd2, 5'd0, 3'd0, 5'd0, 4'd0};
    vecs[1]  = '{5'd9, 3'd1, 1'b1, 1'b0, 5'd0, 3'd0, 5'd8, 3'd1, 5'd0, 4'd1};
    vecs[2]  = '{5'd9, 3'd1, 1'b0, 1'b0, 5'd9, 3'd1, 5'd0, 3'd0, 5'd8, 4'd1};
    vecs[3]  = '{5'd5, 3'd3, 1'b0, 1'b0, 5'd5, 3'd3, 5'd9, 3'd0, 5'd0, 4'd1};
    vecs[4]  = '{5'd6, 3'd1, 1'b1, 1'b1, 5'd5, 3'd2, 5'd0, 3'd0, 5'd9, 4'd2};
    vecs[5]  = '{5'd6, 3'd1, 1'b1, 1'b1, 5'd5, 3'd1, 5'd0, 3'd0, 5'd0, 4'd3};
    vecs[6]  = '{5'd6, 3'd1, 1'b1, 1'b1, 5'd5, 3'd0, 5'd0, 3'd0, 5'd0, 4'd4};
    vecs[7]  = '{5'd6, 3'd1, 1'b1, 1'b1, 5'd5, 3'd0, 5'd0, 3'd0, 5'd0, 4'd5};
    vecs[8]  = '{5'd0, 3'd2, 1'b0, 1'b0, 5'd0, 3'd0, 5'd5, 3'd0, 5'd0, 4'd5};
    vecs[9]  = '{5'd3, 3'd0, 1'b0, 1'b0, 5'd3, 3'd0, 5'd0, 3'd0, 5'd5, 4'd5};
    vecs[10] = '{5'd4, 3'd7, 1'b0, 1'b0, 5'd4, 3'd7, 5'd3, 3'd0, 5'd0, 4'd5};
    vecs[11] = '{5'd0, 3'd0, 1'b0, 1'b0, 5'd0, 3'd0, 5'd4, 3'd6, 5'd3, 4'd5};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero("in_reset");
    reset_n = 1'b1;
    #1;
    check_zero("after_release");

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].d_addr, vecs[i].d_tnew, vecs[i].s, vecs[i].h);
      chk($sformatf("vec%0d.E_RegAddr", i), E_RegAddr, vecs[i].e_addr);
      chk($sformatf("vec%0d.E_Tnew", i), E_Tnew, vecs[i].e_tnew);
      chk($sformatf("vec%0d.M_RegAddr", i), M_RegAddr, vecs[i].m_addr);
      chk($sformatf("vec%0d.M_Tnew", i), M_Tnew, vecs[i].m_tnew);
      chk($sformatf("vec%0d.W_RegAddr", i), W_RegAddr, vecs[i].w_addr);
      chk($sformatf("vec%0d.E_fwd_ok", i), E_fwd_ok,
          (vecs[i].e_addr != 0) && (vecs[i].e_tnew == 0));
      chk($sformatf("vec%0d.M_fwd_ok", i), M_fwd_ok,
          (vecs[i].m_addr != 0) && (vecs[i].m_tnew == 0));
      chk($sformatf("vec%0d.stall_cnt", i), stall_cnt, vecs[i].cnt);
    end

    for (int i = 0; i < 300; i++) begin
      logic [AW-1:0] a;
      logic [TW-1:0] t;
      logic s, h;
      a = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom_range(1, 31));
      t = TW'($urandom_range(0, 7));
      s = ($urandom_range(0, 3) == 0);
      h = ($urandom_range(0, 4) == 0);
      step(a, t, s, h);
      check_model("rand");
    end

    // Counter wrap from a clean reset.
    reset_n = 1'b0;
    #1;
    model_reset();
    check_zero("reset_pulse");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 15; i++) step(5'd1, 3'd1, 1'b1, 1'b0);
    chk("wrap.cnt_max", stall_cnt, 15);
    step(5'd1, 3'd1, 1'b1, 1'b0);
    chk("wrap.cnt_zero", stall_cnt, 0);
    check_model("wrap");

    // Asynchronous reset mid-cycle with an entry in flight.
    step(5'd7, 3'd1, 1'b0, 1'b0);
    chk("async.pre_E_RegAddr", E_RegAddr, 7);
    chk("async.pre_E_Tnew", E_Tnew, 1);
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_zero("async_mid_cycle");
    @(posedge clk);
    #1;
    check_zero("async_held");
    reset_n = 1'b1;
    step(5'd2, 3'd1, 1'b0, 1'b0);
    check_model("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
